// File: rtl/sw_pkg.sv
// -----------------------------------------------------------------------------
// sw_pkg
//   Shared definitions for the input-buffer route controller:
//     - flow_t  : flit flow-type encoding seen at the FIFO head
//     - state_t : route-controller FSM states
//     - NPORT_DEF / CDEPTH_DEF : default port count and downstream buffer depth
//     - is_body(): true for flits that belong inside a packet (DATA or TAIL)
// -----------------------------------------------------------------------------
package sw_pkg;

  localparam int NPORT_DEF  = 4;
  localparam int CDEPTH_DEF = 4;

  typedef enum logic [1:0] {
    EMPT = 2'b00,
    DATA = 2'b01,
    HEAD = 2'b10,
    TAIL = 2'b11
  } flow_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    XFER = 2'b10
  } state_t;

  function automatic logic is_body(input flow_t f);
    return (f == DATA) || (f == TAIL);
  endfunction

endpackage

// File: rtl/credit_cnt.sv
// -----------------------------------------------------------------------------
// credit_cnt
//   One saturating up/down credit counter for a single downstream port.
//   Resets to CDEPTH (downstream buffer empty). An increment and a decrement in
//   the same cycle cancel. An increment while already at CDEPTH is dropped and
//   flagged on o_ovf.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   i_inc     : returned credit pulse
//   i_dec     : flit sent to this port
//   o_nz      : credit available (count > 0)
//   o_ovf     : credit returned while already full (combinational)
// -----------------------------------------------------------------------------
module credit_cnt #(
  parameter int CDEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_nz,
  output logic o_ovf
);

  localparam int W = $clog2(CDEPTH + 1);
  localparam logic [W-1:0] FULL = W'(CDEPTH);

  logic [W-1:0] r_cnt;
  logic         w_full;

  assign w_full = (r_cnt == FULL);
  assign o_nz   = (r_cnt != '0);
  assign o_ovf  = i_inc && !i_dec && w_full;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= FULL;
    end else if (i_inc && !i_dec) begin
      if (!w_full) r_cnt <= r_cnt + 1'b1;
    end else if (i_dec && !i_inc) begin
      if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/ib_route_ctrl.sv
// -----------------------------------------------------------------------------
// ib_route_ctrl
//   Input-buffer route controller. Watches the flit at the head of an input
//   FIFO, requests the output port computed for a HEAD flit, waits for the
//   arbiter grant and then streams the packet out until its TAIL flit.
//   Stray DATA/TAIL flits seen while idle are discarded and flagged.
//
// Configuration macro:
//   IB_CREDIT_EN - when defined, per-port credit counters gate the transfer;
//                  when undefined, credit is always available and cred_ret
//                  is ignored.
//
// Ports:
//   clk       : clock
//   rst       : asynchronous active-high reset
//   flowb     : flow type of the FIFO head flit (sw_pkg::flow_t)
//   empty     : FIFO empty flag
//   re        : FIFO read enable (one flit per cycle)
//   reqi      : one-hot route of the head flit (valid with HEAD)
//   req       : registered one-hot request to the output arbiter
//   ack       : level grant from the arbiter
//   cred_ret  : per-port credit return pulses
//   pkt_cnt   : completed packet count (wraps)
//   err       : sticky protocol-error flag
// -----------------------------------------------------------------------------
module ib_route_ctrl
  import sw_pkg::*;
#(
  parameter int NPORT  = NPORT_DEF,
  parameter int CDEPTH = CDEPTH_DEF,
  parameter int CNTW   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       flowb,
  input  logic             empty,
  output logic             re,
  input  logic [NPORT-1:0] reqi,
  output logic [NPORT-1:0] req,
  input  logic             ack,
  input  logic [NPORT-1:0] cred_ret,
  output logic [CNTW-1:0]  pkt_cnt,
  output logic             err
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [NPORT-1:0]  r_req;
  logic [CNTW-1:0]   r_pkt_cnt;
  logic              r_err;
  logic              r_first;     // next XFER read is the packet's HEAD

  flow_t             w_flow;
  logic              w_re;
  logic              w_discard;
  logic              w_start;
  logic              w_grant;
  logic              w_tail_rd;
  logic              w_head_err;
  logic              w_credit_ok;
  logic              w_cred_ovf;

  assign w_flow = flow_t'(flowb);

`ifdef IB_CREDIT_EN
  logic [NPORT-1:0] w_cred_nz;
  logic [NPORT-1:0] w_cred_ovf_v;

  for (genvar g = 0; g < NPORT; g++) begin : g_cred
    credit_cnt #(.CDEPTH(CDEPTH)) u_credit_cnt (
      .clk   (clk),
      .rst   (rst),
      .i_inc (cred_ret[g]),
      .i_dec (re && r_req[g]),
      .o_nz  (w_cred_nz[g]),
      .o_ovf (w_cred_ovf_v[g])
    );
  end

  // req is one-hot while transferring, so this selects the requested port.
  assign w_credit_ok = |(r_req & w_cred_nz);
  assign w_cred_ovf  = |w_cred_ovf_v;
`else
  logic w_unused_cfg;

  assign w_credit_ok  = 1'b1;
  assign w_cred_ovf   = 1'b0;
  assign w_unused_cfg = (^cred_ret) ^ (CDEPTH > 0);
`endif

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    w_state_nxt = r_state;
    w_re        = 1'b0;
    w_discard   = 1'b0;
    w_start     = 1'b0;
    w_grant     = 1'b0;
    w_tail_rd   = 1'b0;
    w_head_err  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!empty && is_body(w_flow)) begin
          // A body flit with no packet open is garbage: drop it.
          w_re      = 1'b1;
          w_discard = 1'b1;
        end else if (!empty && (w_flow == HEAD) && (|reqi)) begin
          w_start     = 1'b1;
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        if (ack) begin
          w_grant     = 1'b1;
          w_state_nxt = XFER;
        end
      end
      XFER: begin
        w_re       = !empty && w_credit_ok;
        w_head_err = w_re && (w_flow == HEAD) && !r_first;
        if (w_re && (w_flow == TAIL)) begin
          w_tail_rd   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Reset must silence the read strobe even though IDLE can discard.
  assign re      = w_re & ~rst;
  assign req     = r_req;
  assign pkt_cnt = r_pkt_cnt;
  assign err     = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_req     <= '0;
      r_pkt_cnt <= '0;
      r_err     <= 1'b0;
      r_first   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start)        r_req <= reqi;
      else if (w_tail_rd) r_req <= '0;
      if (w_tail_rd) r_pkt_cnt <= r_pkt_cnt + 1'b1;
      if (w_grant)   r_first <= 1'b1;
      else if (w_re) r_first <= 1'b0;
      if (w_discard || w_head_err || w_cred_ovf) r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ib_route_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ib_route_ctrl
//   Self-checking bench for ib_route_ctrl (NPORT=4, CDEPTH=4, CNTW=4).
//   A queue stands in for the input FIFO; a packet-level reference model
//   predicts re/req/pkt_cnt/err every cycle. Honors IB_CREDIT_EN.
// -----------------------------------------------------------------------------
module tb_ib_route_ctrl;
  import sw_pkg::*;

  localparam int TB_NPORT  = 4;
  localparam int TB_CDEPTH = 4;
  localparam int TB_CNTW   = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [1:0]          flowb;
  logic                empty;
  logic                re;
  logic [TB_NPORT-1:0] reqi;
  logic [TB_NPORT-1:0] req;
  logic                ack;
  logic [TB_NPORT-1:0] cred_ret;
  logic [TB_CNTW-1:0]  pkt_cnt;
  logic                err;

  ib_route_ctrl #(.NPORT(TB_NPORT), .CDEPTH(TB_CDEPTH), .CNTW(TB_CNTW)) dut (
    .clk      (clk),
    .rst      (rst),
    .flowb    (flowb),
    .empty    (empty),
    .re       (re),
    .reqi     (reqi),
    .req      (req),
    .ack      (ack),
    .cred_ret (cred_ret),
    .pkt_cnt  (pkt_cnt),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] f;
    logic [3:0] r;
  } flit_t;

  flit_t fifo[$];

  // Reference model: packet-level view of the controller.
  bit         m_busy;      // a route request is outstanding or in progress
  bit         m_granted;   // arbiter has granted it
  bit         m_first;     // next forwarded flit opens the packet
  bit         m_err;
  logic [3:0] m_req;
  int         m_pkt;
  int         m_cred[TB_NPORT];

  // Stimulus knobs and observation counters.
  bit hold_ack;
  bit auto_ret;
  int pulse_port = -1;
  int reads;
  int cyc;
  int first_rd;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int port_of(input logic [3:0] oh);
    for (int p = 0; p < TB_NPORT; p++) if (oh[p]) return p;
    return 0;
  endfunction

  function automatic bit credit_avail(input logic [3:0] oh);
`ifdef IB_CREDIT_EN
    return m_cred[port_of(oh)] > 0;
`else
    return (oh != 0);
`endif
  endfunction

  task automatic m_reset();
    m_busy = 0; m_granted = 0; m_first = 0; m_err = 0; m_req = '0; m_pkt = 0;
    for (int p = 0; p < TB_NPORT; p++) m_cred[p] = TB_CDEPTH;
    fifo.delete();
  endtask

  task automatic push(input flow_t f, input logic [3:0] r);
    flit_t x;
    x.f = f;
    x.r = r;
    fifo.push_back(x);
  endtask

  task automatic push_pkt(input int port, input int ndata);
    push(HEAD, 4'(1 << port));
    for (int i = 0; i < ndata; i++) push(DATA, 4'($urandom));
    push(TAIL, 4'($urandom));
  endtask

  // One clock cycle: drive at the falling edge, check, advance model at rise.
  task automatic step();
    bit e_re;
    if (fifo.size() > 0) begin
      empty = 1'b0; flowb = fifo[0].f; reqi = fifo[0].r;
    end else begin
      empty = 1'b1; flowb = 2'($urandom); reqi = 4'($urandom);
    end
    ack = m_busy && !hold_ack;
    for (int p = 0; p < TB_NPORT; p++) begin
`ifdef IB_CREDIT_EN
      cred_ret[p] = (auto_ret && m_cred[p] < TB_CDEPTH && $urandom_range(0, 1) == 1) || (pulse_port == p);
`else
      cred_ret[p] = (auto_ret && $urandom_range(0, 1) == 1) || (pulse_port == p);
`endif
    end
    pulse_port = -1;
    #1;
    if (!m_busy)         e_re = !empty && (flowb == DATA || flowb == TAIL);
    else if (!m_granted) e_re = 1'b0;
    else                 e_re = !empty && credit_avail(m_req);
    check("re", 32'(re), 32'(e_re));
    check("req", 32'(req), 32'(m_req));
    check("pkt_cnt", 32'(pkt_cnt), 32'(m_pkt));
    check("err", 32'(err), 32'(m_err));
    if (re === 1'b1) begin
      reads++;
      if (first_rd < 0) first_rd = cyc;
    end
    cyc++;
    @(posedge clk);
`ifdef IB_CREDIT_EN
    for (int p = 0; p < TB_NPORT; p++) begin
      m_cred[p] += int'(cred_ret[p]) - int'(e_re && m_busy && m_granted && m_req[p]);
      if (m_cred[p] > TB_CDEPTH) begin
        m_cred[p] = TB_CDEPTH;
        m_err = 1;
      end
    end
`endif
    if (!m_busy) begin
      if (e_re) m_err = 1;
      else if (!empty && flowb == HEAD && reqi != 0) begin
        m_busy = 1;
        m_req  = reqi;
      end
    end else if (!m_granted) begin
      if (ack) begin
        m_granted = 1;
        m_first   = 1;
      end
    end else if (e_re) begin
      if (flowb == HEAD && !m_first) m_err = 1;
      m_first = 0;
      if (flowb == TAIL) begin
        m_busy = 0; m_granted = 0; m_req = '0;
        m_pkt  = (m_pkt + 1) % (1 << TB_CNTW);
      end
    end
    if (e_re) void'(fifo.pop_front());
    @(negedge clk);
  endtask

  task automatic run_idle(input string tag, input int budget);
    int n = 0;
    while ((fifo.size() > 0 || m_busy) && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(fifo.size() == 0 && !m_busy), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_reset();
    // A body flit at the head proves re stays low during reset.
    empty = 1'b0; flowb = DATA; reqi = 4'b0010; ack = 1'b0; cred_ret = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_re", 32'(re), 32'd0);
    check("rst_req", 32'(req), 32'd0);
    check("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit full;
    hold_ack = 0;
    auto_ret = 1;

    // Reset, then a 3-flit packet to port 2 with minimum latency.
    do_reset();
    reads = 0; cyc = 0; first_rd = -1;
    push_pkt(2, 1);
    run_idle("t1_drain", 20);
    check("t1_reads", 32'(reads), 32'd3);
    check("t1_head_read_cycle", 32'(first_rd), 32'd2);
    check("t1_pkt_cnt", 32'(pkt_cnt), 32'd1);
    check("t1_req_clear", 32'(req), 32'd0);

    // Grant withheld for 5 cycles.
    push_pkt(2, 2);
    step();
    hold_ack = 1;
    reads = 0;
    repeat (5) begin
      step();
      check("hold_req", 32'(req), 32'b0100);
    end
    check("hold_no_reads", 32'(reads), 32'd0);
    hold_ack = 0;
    cyc = 0; first_rd = -1;
    run_idle("t2_drain", 20);
    check("hold_start_cycle", 32'(first_rd), 32'd1);
    check("hold_reads", 32'(reads), 32'd4);

    // Credit gating on a 6-flit packet.
    do_reset();
    auto_ret = 0;
    reads = 0;
    push_pkt(1, 4);
`ifdef IB_CREDIT_EN
    repeat (12) step();
    check("cred_stall_reads", 32'(reads), 32'd4);
    pulse_port = 1;
    repeat (6) step();
    check("cred_one_more", 32'(reads), 32'd5);
    auto_ret = 1;
    run_idle("cred_drain", 100);
    n = 0;
    full = 0;
    while (!full && n < 200) begin
      step();
      n++;
      full = 1;
      for (int p = 0; p < TB_NPORT; p++) if (m_cred[p] != TB_CDEPTH) full = 0;
    end
    auto_ret = 0;
    check("cred_refilled", 32'(full), 32'd1);
    check("sat_err_before", 32'(err), 32'd0);
    pulse_port = 0;
    step();
    step();
    check("sat_err", 32'(err), 32'd1);
`else
    run_idle("nocred_drain", 40);
    check("nocred_reads", 32'(reads), 32'd6);
`endif
    auto_ret = 1;

    // Stray DATA while idle is discarded and flags err.
    do_reset();
    reads = 0;
    push(DATA, 4'b0001);
    step();
    check("disc_read", 32'(reads), 32'd1);
    check("disc_req", 32'(req), 32'd0);
    repeat (3) step();
    check("disc_err_sticky", 32'(err), 32'd1);
    check("disc_single_read", 32'(reads), 32'd1);
    push_pkt(3, 1);
    run_idle("disc_after_pkt", 20);
    check("disc_pkt_cnt", 32'(pkt_cnt), 32'd1);

    // Reset in the middle of a packet.
    do_reset();
    push_pkt($urandom_range(0, 3), 4);
    reads = 0;
    n = 0;
    while (reads < 2 && n < 20) begin
      step();
      n++;
    end
    check("mid_two_reads", 32'(reads), 32'd2);
    rst = 1'b1;
    #1;
    check("mid_rst_req", 32'(req), 32'd0);
    check("mid_rst_re", 32'(re), 32'd0);
    check("mid_rst_pkt", 32'(pkt_cnt), 32'd0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    push_pkt(0, 2);
    run_idle("mid_next_pkt", 20);
    check("mid_pkt_cnt", 32'(pkt_cnt), 32'd1);

    // Randomized traffic: normal packets, stray body flits, rogue HEADs.
    for (int i = 0; i < 30; i++) begin
      int kind = $urandom_range(0, 7);
      int port = $urandom_range(0, 3);
      hold_ack = ($urandom_range(0, 3) == 0);
      if (kind == 0) begin
        push(($urandom_range(0, 1) == 1) ? TAIL : DATA, 4'($urandom));
      end else if (kind == 1) begin
        push(HEAD, 4'(1 << port));
        push(DATA, 4'($urandom));
        push(HEAD, 4'($urandom));
        push(TAIL, 4'($urandom));
      end else begin
        push_pkt(port, $urandom_range(0, 3));
      end
      repeat ($urandom_range(0, 3)) step();
      hold_ack = 0;
      run_idle("rand_drain", 200);
      repeat ($urandom_range(0, 2)) step();
    end

    // Counter wrap: 17 packets on a 4-bit counter.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      push_pkt($urandom_range(0, 3), $urandom_range(0, 2));
      run_idle("wrap_drain", 100);
    end
    check("wrap_pkt_cnt", 32'(pkt_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
